// File: rtl/operands_bypass_if.sv
// Operand-stage bus: decoder issue, writeback ports and registered operand outputs.
// The parameters must match the ones given to operands_bypass.
interface operands_bypass_if #(
  parameter int LANES = 2,
  parameter int NSRC  = 3,
  parameter int NWB   = 2,
  parameter int XLEN  = 64,
  parameter int SID_W = 5,
  parameter int CTL_W = 24
);
  logic                        flush_i;
  logic [LANES-1:0]            stall_i;
  logic [LANES-1:0]            dec_valid_i;
  logic [LANES*NSRC-1:0]       dec_rs_valid_i;
  logic [LANES*NSRC*5-1:0]     dec_rs_i;
  logic [LANES*5-1:0]          dec_rd_i;
  logic [LANES*CTL_W-1:0]      dec_ctl_i;
  logic [LANES*SID_W-1:0]      dec_sid_i;
  logic [LANES-1:0]            op_valid_o;
  logic [LANES*NSRC-1:0]       op_rs_valid_o;
  logic [LANES*NSRC*5-1:0]     op_rs_o;
  logic [LANES*NSRC*XLEN-1:0]  op_rs_value_o;
  logic [LANES*5-1:0]          op_rd_o;
  logic [LANES*CTL_W-1:0]      op_ctl_o;
  logic [LANES*SID_W-1:0]      op_sid_o;
  logic [NWB-1:0]              wb_valid_i;
  logic [NWB*5-1:0]            wb_rd_i;
  logic [NWB*XLEN-1:0]         wb_data_i;

  modport master (
    output flush_i, stall_i, dec_valid_i, dec_rs_valid_i, dec_rs_i, dec_rd_i,
           dec_ctl_i, dec_sid_i, wb_valid_i, wb_rd_i, wb_data_i,
    input  op_valid_o, op_rs_valid_o, op_rs_o, op_rs_value_o, op_rd_o,
           op_ctl_o, op_sid_o
  );

  modport slave (
    input  flush_i, stall_i, dec_valid_i, dec_rs_valid_i, dec_rs_i, dec_rd_i,
           dec_ctl_i, dec_sid_i, wb_valid_i, wb_rd_i, wb_data_i,
    output op_valid_o, op_rs_valid_o, op_rs_o, op_rs_value_o, op_rd_o,
           op_ctl_o, op_sid_o
  );
endinterface

// File: rtl/operands_bypass.sv
// Operand-read stage: owns the integer register file, captures operands at issue
// and forwards writebacks both at capture and into lanes held by a stall.
module operands_bypass #(
  parameter int LANES = 2,
  parameter int NSRC  = 3,
  parameter int NWB   = 2,
  parameter int XLEN  = 64,
  parameter int SID_W = 5,
  parameter int CTL_W = 24
) (
  input  logic           clk,
  input  logic           rst,
  operands_bypass_if.slave bus
);
  localparam int NOPS = LANES * NSRC;

  logic [XLEN-1:0]        rf_r [32];
  logic [LANES-1:0]       op_valid_r;
  logic [NOPS-1:0]        op_rs_valid_r;
  logic [NOPS*5-1:0]      op_rs_r;
  logic [NOPS*XLEN-1:0]   op_value_r;
  logic [LANES*5-1:0]     op_rd_r;
  logic [LANES*CTL_W-1:0] op_ctl_r;
  logic [LANES*SID_W-1:0] op_sid_r;

  logic [NOPS*XLEN-1:0]   load_val_s;
  logic [NOPS*XLEN-1:0]   refresh_val_s;

  // Read values for loading lanes and refreshed values for held lanes; later ports override earlier ones.
  always_comb begin
    load_val_s    = '0;
    refresh_val_s = '0;
    for (int i = 0; i < NOPS; i++) begin
      if (bus.dec_rs_valid_i[i] && (bus.dec_rs_i[i*5 +: 5] != 5'd0)) begin
        load_val_s[i*XLEN +: XLEN] = rf_r[bus.dec_rs_i[i*5 +: 5]];
        for (int w = 0; w < NWB; w++) begin
          load_val_s[i*XLEN +: XLEN] =
            (bus.wb_valid_i[w] && (bus.wb_rd_i[w*5 +: 5] == bus.dec_rs_i[i*5 +: 5]))
            ? bus.wb_data_i[w*XLEN +: XLEN] : load_val_s[i*XLEN +: XLEN];
        end
      end else begin
        load_val_s[i*XLEN +: XLEN] = '0;
      end

      refresh_val_s[i*XLEN +: XLEN] = op_value_r[i*XLEN +: XLEN];
      if (op_valid_r[i/NSRC] && op_rs_valid_r[i] && (op_rs_r[i*5 +: 5] != 5'd0)) begin
        for (int w = 0; w < NWB; w++) begin
          refresh_val_s[i*XLEN +: XLEN] =
            (bus.wb_valid_i[w] && (bus.wb_rd_i[w*5 +: 5] == op_rs_r[i*5 +: 5]))
            ? bus.wb_data_i[w*XLEN +: XLEN] : refresh_val_s[i*XLEN +: XLEN];
        end
      end else begin
        refresh_val_s[i*XLEN +: XLEN] = op_value_r[i*XLEN +: XLEN];
      end
    end
  end

  // Register file write; the last port in loop order wins a same-index conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        rf_r[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NWB; w++) begin
        if (bus.wb_valid_i[w] && (bus.wb_rd_i[w*5 +: 5] != 5'd0)) begin
          rf_r[bus.wb_rd_i[w*5 +: 5]] <= bus.wb_data_i[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Per-lane pipeline register: flush beats stall, stall holds and refreshes values.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid_r    <= '0;
      op_rs_valid_r <= '0;
      op_rs_r       <= '0;
      op_value_r    <= '0;
      op_rd_r       <= '0;
      op_ctl_r      <= '0;
      op_sid_r      <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (bus.flush_i) begin
          op_valid_r[l] <= 1'b0;
        end else if (!bus.stall_i[l]) begin
          op_valid_r[l]                <= bus.dec_valid_i[l];
          op_rd_r[l*5 +: 5]            <= bus.dec_rd_i[l*5 +: 5];
          op_ctl_r[l*CTL_W +: CTL_W]   <= bus.dec_ctl_i[l*CTL_W +: CTL_W];
          op_sid_r[l*SID_W +: SID_W]   <= bus.dec_sid_i[l*SID_W +: SID_W];
          for (int s = 0; s < NSRC; s++) begin
            op_rs_valid_r[l*NSRC+s]              <= bus.dec_rs_valid_i[l*NSRC+s];
            op_rs_r[(l*NSRC+s)*5 +: 5]           <= bus.dec_rs_i[(l*NSRC+s)*5 +: 5];
            op_value_r[(l*NSRC+s)*XLEN +: XLEN]  <= load_val_s[(l*NSRC+s)*XLEN +: XLEN];
          end
        end else begin
          for (int s = 0; s < NSRC; s++) begin
            op_value_r[(l*NSRC+s)*XLEN +: XLEN] <= refresh_val_s[(l*NSRC+s)*XLEN +: XLEN];
          end
        end
      end
    end
  end

  assign bus.op_valid_o    = op_valid_r;
  assign bus.op_rs_valid_o = op_rs_valid_r;
  assign bus.op_rs_o       = op_rs_r;
  assign bus.op_rs_value_o = op_value_r;
  assign bus.op_rd_o       = op_rd_r;
  assign bus.op_ctl_o      = op_ctl_r;
  assign bus.op_sid_o      = op_sid_r;
endmodule
